// File: rtl/shli_pipe.sv
// -----------------------------------------------------------------------------
// shli_pipe: pipelined logical shift-left unit, result = lhs << rhs.
//
// The lhs and rhs channels are joined and each operation passes through a
// registered log2 barrel shifter. There are NUM_STAGES = $clog2(DATA_TYPE)
// stages, so the latency is NUM_STAGES cycles and the throughput is one
// operation per cycle.
//
// Handshake (valid/ready on every channel): a transfer happens on a rising
// clock edge where both valid and ready are high. A producer holds its
// valid and data until that edge. The two input channels are joined. Neither
// is consumed alone, so each ready also depends on the partner's valid.
// Ready is combinational from result_ready. No path runs from lhs/rhs data to
// any output.
//
// Optional feature: define SHLI_PIPE_OVERFLOW_EN to add result_overflow. It is
// set when a '1' bit of lhs is shifted out past the MSB.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous, active-high reset
//   lhs             in   [DATA_TYPE] value to shift
//   lhs_valid/ready in/out lhs channel handshake
//   rhs             in   [DATA_TYPE] unsigned shift amount
//   rhs_valid/ready in/out rhs channel handshake
//   result          out  [DATA_TYPE] shifted value
//   result_valid    out  result channel valid
//   result_ready    in   downstream ready
//   result_overflow out  (SHLI_PIPE_OVERFLOW_EN only) qualified by result_valid
// -----------------------------------------------------------------------------
module shli_pipe #(
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  output logic                 lhs_ready,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  output logic                 rhs_ready,
  output logic [DATA_TYPE-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready
`ifdef SHLI_PIPE_OVERFLOW_EN
  ,
  output logic                 result_overflow
`endif
);

  localparam int NUM_STAGES = $clog2(DATA_TYPE);
  localparam logic [DATA_TYPE-1:0] ALL_ONES = '1;

  // Per-stage registers
  logic [NUM_STAGES-1:0] r_valid;
  logic [NUM_STAGES-1:0] r_zero;
  logic [DATA_TYPE-1:0]  r_data [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_amt  [NUM_STAGES];
`ifdef SHLI_PIPE_OVERFLOW_EN
  logic [NUM_STAGES-1:0] r_ovf;
`endif

  logic [NUM_STAGES-1:0] w_load;
  logic                  w_accept;
  logic                  w_zero0;
  logic [DATA_TYPE-1:0]  w_data0;
  logic                  w_ovf0;
  logic                  w_unused_amt;

  // Stage k may load if it, or any later stage, is empty, or if the output
  // drains. This closed form replaces the recursive chain
  // load_k = ~valid_k | load_{k+1}.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_load
    assign w_load[k] = result_ready | ~(&r_valid[NUM_STAGES-1:k]);
  end

  assign w_accept  = lhs_valid & rhs_valid & w_load[0];
  assign lhs_ready = rhs_valid & w_load[0];
  assign rhs_ready = lhs_valid & w_load[0];

  // Stage 0 applies rhs[0] directly. Any set bit at or above NUM_STAGES means
  // the shift is at least 2^NUM_STAGES >= DATA_TYPE, so the result is zero.
  always_comb begin
    w_zero0 = |rhs[DATA_TYPE-1:NUM_STAGES];
    w_data0 = rhs[0] ? (lhs << 1) : lhs;
    w_ovf0  = (rhs[0] & lhs[DATA_TYPE-1]) | (w_zero0 & (|lhs));
  end

  // Bit 0 of every amount register, and all of the last stage's amount
  // register, are never used as shift controls.
  always_comb begin
    w_unused_amt = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_unused_amt = w_unused_amt ^ (^r_amt[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_zero  <= '0;
`ifdef SHLI_PIPE_OVERFLOW_EN
      r_ovf   <= '0;
`endif
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= w_accept;
        r_data[0]  <= w_data0;
        r_amt[0]   <= rhs[NUM_STAGES-1:0];
        r_zero[0]  <= w_zero0;
`ifdef SHLI_PIPE_OVERFLOW_EN
        r_ovf[0]   <= w_ovf0;
`endif
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_amt[k-1][k] ? (r_data[k-1] << (1 << k)) : r_data[k-1];
          r_amt[k]   <= r_amt[k-1];
          r_zero[k]  <= r_zero[k-1];
`ifdef SHLI_PIPE_OVERFLOW_EN
          // The top 2^k bits are lost when this stage shifts.
          r_ovf[k]   <= r_ovf[k-1] |
                        (r_amt[k-1][k] & (|(r_data[k-1] & ~(ALL_ONES >> (1 << k)))));
`endif
        end
      end
    end
  end

  assign result_valid = r_valid[NUM_STAGES-1];
  assign result       = r_zero[NUM_STAGES-1] ? '0 : r_data[NUM_STAGES-1];
`ifdef SHLI_PIPE_OVERFLOW_EN
  assign result_overflow = r_ovf[NUM_STAGES-1];
`else
  // The overflow term is computed only when the feature is built in.
  logic w_unused_ovf0;
  assign w_unused_ovf0 = w_ovf0 ^ ALL_ONES[0];
`endif

endmodule

// File: tb/tb_shli_pipe.sv
// -----------------------------------------------------------------------------
// tb_shli_pipe: self-checking bench for shli_pipe with DATA_TYPE=32.
// Table-driven single operations, then sequences for join, backpressure and
// asynchronous reset. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_shli_pipe;
  localparam int DW = 32;
  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] lhs, rhs, result;
  logic          lhs_valid, rhs_valid, lhs_ready, rhs_ready;
  logic          result_valid, result_ready;
`ifdef SHLI_PIPE_OVERFLOW_EN
  logic          result_overflow;
`endif

  shli_pipe #(.DATA_TYPE(DW)) dut (
    .clk(clk), .rst(rst),
    .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
`ifdef SHLI_PIPE_OVERFLOW_EN
    , .result_overflow(result_overflow)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] exp;
    logic          ovf;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
    else n_pass++;
  endtask

  // One operation into an empty pipeline with result_ready=1. Latency counts
  // edges from the accepting edge to the edge after which result_valid is seen.
  task automatic send_one(input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic [DW-1:0] exp, input logic eovf, input string name);
    int lat;
    @(posedge clk); #1;
    lhs = l; rhs = r; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    while (!result_valid && lat < 20) begin
      @(posedge clk); lat++; #1;
    end
    check({name, " latency"}, DW'(lat), DW'(NS));
    check({name, " result"}, result, exp);
`ifdef SHLI_PIPE_OVERFLOW_EN
    check({name, " overflow"}, {31'd0, result_overflow}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("note: unknown overflow expectation for %s", name);
`endif
  endtask

  initial begin
    int idx, n_got, iters, n_res;
    bit acc;
    logic [DW-1:0] last;

    vecs[0]  = '{32'h00000001, 32'd4,        32'h00000010, 1'b0};
    vecs[1]  = '{32'h00000001, 32'd31,       32'h80000000, 1'b0};
    vecs[2]  = '{32'hDEADBEEF, 32'd32,       32'h00000000, 1'b1};
    vecs[3]  = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[4]  = '{32'h00000000, 32'd32,       32'h00000000, 1'b0};
    vecs[5]  = '{32'hC0000001, 32'd1,        32'h80000002, 1'b1};
    vecs[6]  = '{32'h40000000, 32'd1,        32'h80000000, 1'b0};
    vecs[7]  = '{32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0};
    vecs[8]  = '{32'h12345678, 32'd8,        32'h34567800, 1'b1};
    vecs[9]  = '{32'h0000FFFF, 32'd16,       32'hFFFF0000, 1'b0};
    vecs[10] = '{32'h00000003, 32'd31,       32'h80000000, 1'b1};
    vecs[11] = '{32'hA5A5A5A5, 32'd33,       32'h00000000, 1'b1};
    vecs[12] = '{32'h0000000F, 32'd29,       32'hE0000000, 1'b1};
    vecs[13] = '{32'hFFFFFFFF, 32'd5,        32'hFFFFFFE0, 1'b1};

    // reset state
    rst = 1'b1; lhs = '0; rhs = '0;
    lhs_valid = 1'b0; rhs_valid = 1'b1; result_ready = 1'b0;
    #12;
    check("reset result_valid", {31'd0, result_valid}, 32'd0);
    check("reset lhs_ready follows rhs_valid", {31'd0, lhs_ready}, 32'd1);
    check("reset rhs_ready follows lhs_valid", {31'd0, rhs_ready}, 32'd0);
    rhs_valid = 1'b0;
    #4 rst = 1'b0;

    // table of single operations
    for (int i = 0; i < 14; i++) begin
      send_one(vecs[i].l, vecs[i].r, vecs[i].exp, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // join: lhs alone is never consumed
    @(posedge clk); #1;
    lhs = 32'd7; rhs = 32'd2; lhs_valid = 1'b1; rhs_valid = 1'b0; result_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("join lhs_ready c%0d", c), {31'd0, lhs_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rhs_valid = 1'b1;
    @(posedge clk); #1;
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    n_res = 0; last = '0;
    for (int c = 0; c < 10; c++) begin
      if (result_valid) begin n_res++; last = result; end
      @(posedge clk); #1;
    end
    check("join result count", DW'(n_res), 32'd1);
    check("join result value", last, 32'd28);

    // backpressure: 10 ops with the output stalled, then release
    result_ready = 1'b0; idx = 0;
    for (int c = 0; c < 10; c++) begin
      lhs = DW'(idx); rhs = 32'd1;
      lhs_valid = (idx < 10); rhs_valid = (idx < 10);
      @(negedge clk);
      acc = lhs_valid & lhs_ready;
      @(posedge clk);
      if (acc) begin exp_q.push_back(DW'(idx * 2)); idx++; end
      #1;
    end
    lhs = DW'(idx); rhs = 32'd1;
    check("stall accepted count", DW'(idx), 32'd5);
    check("stall lhs_ready", {31'd0, lhs_ready}, 32'd0);
    check("stall result_valid held", {31'd0, result_valid}, 32'd1);
    check("stall result held", result, 32'd0);
    result_ready = 1'b1; n_got = 0; iters = 0;
    while (n_got < 10 && iters < 40) begin
      lhs = DW'(idx); rhs = 32'd1;
      lhs_valid = (idx < 10); rhs_valid = (idx < 10);
      @(negedge clk);
      iters++;
      acc = lhs_valid & lhs_ready;
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected result", result, 32'hFFFFFFFF);
        end else begin
          check($sformatf("stream result %0d", n_got), result, exp_q.pop_front());
        end
        n_got++;
      end
      @(posedge clk);
      if (acc) begin exp_q.push_back(DW'(idx * 2)); idx++; end
      #1;
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    check("stream result count", DW'(n_got), 32'd10);
    check("stream cycles after release", DW'(iters), 32'd10);
    check("stream leftover expected", DW'(exp_q.size()), 32'd0);

    // asynchronous reset with 3 ops in flight
    repeat (3) @(posedge clk);
    #1;
    result_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      lhs = DW'(5 + c); rhs = 32'd3; lhs_valid = 1'b1; rhs_valid = 1'b1;
      @(posedge clk); #1;
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    iters = 0;
    while (!result_valid && iters < 10) begin @(posedge clk); iters++; #1; end
    check("pre-reset result_valid", {31'd0, result_valid}, 32'd1);
    check("pre-reset result", result, 32'd40);
    #2 rst = 1'b1;
    #1;
    check("async reset drops result_valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; result_ready = 1'b1;
    n_res = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (result_valid) n_res++;
    end
    check("no stale results after reset", DW'(n_res), 32'd0);
    send_one(32'd9, 32'd4, 32'h90, 1'b0, "post-reset op");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
